// File: rtl/core_id_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_id_scoreboard_pkg
//  Description : Shared constants for the ID-stage in-flight scoreboard.
//                Provides the core-wide defines (register index width,
//                scoreboard depth, done-channel numbering) and package
//                localparams derived from them.
//                Optional feature macro used by the scoreboard: CORE_SB_FWD_EN
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef CORE_RFIDX_WIDTH
`define CORE_RFIDX_WIDTH 5
`endif
`ifndef CORE_SB_DEPTH
`define CORE_SB_DEPTH 4
`endif
`ifndef CORE_SB_DONE_EX
`define CORE_SB_DONE_EX 0
`endif
`ifndef CORE_SB_DONE_LS
`define CORE_SB_DONE_LS 1
`endif

package core_id_scoreboard_pkg;

    localparam int SB_DEPTH       = `CORE_SB_DEPTH;
    localparam int SB_RFIDX_WIDTH = `CORE_RFIDX_WIDTH;
    localparam int SB_NUM_DONE    = 2;

    // Result-available report channels
    typedef enum int {
        SB_DONE_EX = `CORE_SB_DONE_EX,
        SB_DONE_LS = `CORE_SB_DONE_LS
    } sb_done_ch_e;

endpackage

`default_nettype wire

// File: rtl/core_id_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : core_id_scoreboard_if
//  Description : Bundle between the pipeline (ID/EX/LS/WB) and the ID-stage
//                scoreboard. master = pipeline side, slave = scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================

interface core_id_scoreboard_if #(
    parameter int TAG_WIDTH   = 2,
    parameter int RFIDX_WIDTH = 5,
    parameter int NUM_DONE    = 2
);
    // Issue from ID
    logic                          issue_valid;
    logic                          issue_ready;
    logic                          issue_rd_wen;
    logic [RFIDX_WIDTH-1:0]        issue_rd_idx;
    logic                          issue_is_load;
    logic [TAG_WIDTH-1:0]          issue_tag;
    // Result availability from EX / LS
    logic [NUM_DONE-1:0]           done_valid;
    logic [NUM_DONE*TAG_WIDTH-1:0] done_tag;
    // Retire from WB, flush from EX
    logic                          retire_valid;
    logic                          flush_valid;
    logic [TAG_WIDTH-1:0]          flush_tag;
    // Source operand lookup
    logic                          rs1_ren;
    logic [RFIDX_WIDTH-1:0]        rs1_idx;
    logic                          rs1_hit;
    logic [TAG_WIDTH-1:0]          rs1_tag;
    logic                          rs2_ren;
    logic [RFIDX_WIDTH-1:0]        rs2_idx;
    logic                          rs2_hit;
    logic [TAG_WIDTH-1:0]          rs2_tag;
    // Status
    logic                          id_stall;
    logic                          empty;

    modport master (
        output issue_valid, issue_rd_wen, issue_rd_idx, issue_is_load,
        output done_valid, done_tag, retire_valid, flush_valid, flush_tag,
        output rs1_ren, rs1_idx, rs2_ren, rs2_idx,
        input  issue_ready, issue_tag, rs1_hit, rs1_tag, rs2_hit, rs2_tag,
        input  id_stall, empty
    );

    modport slave (
        input  issue_valid, issue_rd_wen, issue_rd_idx, issue_is_load,
        input  done_valid, done_tag, retire_valid, flush_valid, flush_tag,
        input  rs1_ren, rs1_idx, rs2_ren, rs2_idx,
        output issue_ready, issue_tag, rs1_hit, rs1_tag, rs2_hit, rs2_tag,
        output id_stall, empty
    );

endinterface

`default_nettype wire

// File: rtl/core_id_sb_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : core_id_sb_lookup
//  Description : Youngest-writer search over the scoreboard entry array for
//                one source operand. Walks from head (oldest) to the youngest
//                slot so the last match found is the youngest writer.
//  Revision    : 1.0 - initial release
// ============================================================================

module core_id_sb_lookup #(
    parameter int DEPTH       = 4,
    parameter int RFIDX_WIDTH = 5,
    parameter bit FWD_EN      = 1'b0,
    localparam int TAG_WIDTH  = $clog2(DEPTH)
) (
    input  wire logic [DEPTH-1:0]                  valid_i,
    input  wire logic [DEPTH-1:0]                  rd_wen_i,
    input  wire logic [DEPTH-1:0][RFIDX_WIDTH-1:0] rd_idx_i,
    input  wire logic [DEPTH-1:0]                  done_i,
    input  wire logic [TAG_WIDTH-1:0]              head_i,
    input  wire logic                              ren_i,
    input  wire logic [RFIDX_WIDTH-1:0]            idx_i,
    output logic                                   hit_o,
    output logic [TAG_WIDTH-1:0]                   tag_o,
    output logic                                   block_o
);

    logic [TAG_WIDTH-1:0] w_pos;
    logic                 w_done;

    // Oldest-to-youngest scan; later matches override earlier ones
    always_comb begin
        hit_o  = 1'b0;
        tag_o  = '0;
        w_done = 1'b0;
        w_pos  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_pos = head_i + TAG_WIDTH'(k);
            if (ren_i && (idx_i != '0) && valid_i[w_pos] &&
                rd_wen_i[w_pos] && (rd_idx_i[w_pos] == idx_i)) begin
                hit_o  = 1'b1;
                tag_o  = w_pos;
                w_done = done_i[w_pos];
            end
        end
    end

    // With forwarding, a completed youngest writer can be bypassed
    assign block_o = hit_o && !(FWD_EN && w_done);

endmodule

`default_nettype wire

// File: rtl/core_id_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : core_id_scoreboard
//  Description : In-order in-flight instruction tracker for the ID stage.
//                Circular queue of DEPTH entries pushed by ID, marked done by
//                EX/LS, popped by WB and truncated by EX commit flushes.
//                Provides combinational RAW lookup and the ID stall.
//                Optional feature macro: CORE_SB_FWD_EN (done writers forward
//                instead of stalling).
//  Revision    : 1.0 - initial release
// ============================================================================

module core_id_scoreboard
    import core_id_scoreboard_pkg::*;
#(
    parameter int DEPTH       = SB_DEPTH,
    parameter int RFIDX_WIDTH = SB_RFIDX_WIDTH,
    parameter int NUM_DONE    = SB_NUM_DONE
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    core_id_scoreboard_if.slave sb
);

    localparam int TAG_WIDTH = $clog2(DEPTH);

`ifdef CORE_SB_FWD_EN
    localparam bit c_FWD_EN = 1'b1;
`else
    localparam bit c_FWD_EN = 1'b0;
`endif

    // Queue state
    logic [TAG_WIDTH-1:0]                  head_q, head_d;
    logic [TAG_WIDTH-1:0]                  tail_q, tail_d;
    logic [TAG_WIDTH:0]                    count_q, count_d;
    logic [DEPTH-1:0]                      valid_q, valid_d;
    logic [DEPTH-1:0]                      rd_wen_q, rd_wen_d;
    logic [DEPTH-1:0][RFIDX_WIDTH-1:0]     rd_idx_q, rd_idx_d;
    logic [DEPTH-1:0]                      is_load_q, is_load_d;
    logic [DEPTH-1:0]                      done_q, done_d;

    logic                                  w_full;
    logic                                  w_empty;
    logic                                  w_issue_fire;
    logic                                  w_retire_fire;
    logic                                  w_flush_fire;
    logic [TAG_WIDTH-1:0]                  w_flush_span;
    logic [TAG_WIDTH:0]                    w_flush_cnt;
    logic [TAG_WIDTH-1:0]                  w_flush_age;
    logic [DEPTH-1:0][TAG_WIDTH-1:0]       w_age;
    logic [DEPTH-1:0]                      w_kill;
    logic                                  w_block1;
    logic                                  w_block2;

    assign w_full        = (count_q == (TAG_WIDTH+1)'(DEPTH));
    assign w_empty       = (count_q == '0);
    // A flush always references a live instruction; a stale tag is ignored
    assign w_flush_fire  = sb.flush_valid && valid_q[sb.flush_tag];
    assign w_issue_fire  = sb.issue_valid && !w_full && !sb.flush_valid;
    assign w_retire_fire = sb.retire_valid && !w_empty;

    // Surviving length after a flush; span 0 with a live flush_tag is a full queue
    assign w_flush_span = sb.flush_tag + TAG_WIDTH'(1) - head_q;
    assign w_flush_cnt  = ((w_flush_span == '0) && valid_q[sb.flush_tag])
                          ? (TAG_WIDTH+1)'(DEPTH) : {1'b0, w_flush_span};
    assign w_flush_age  = sb.flush_tag - head_q;

    // Entries strictly younger than the flushing instruction are killed
    always_comb begin
        w_age  = '0;
        w_kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_age[i]  = TAG_WIDTH'(i) - head_q;
            w_kill[i] = w_flush_fire && valid_q[i] && (w_age[i] > w_flush_age);
        end
    end

    // Next-state computation: done, flush, retire, then issue
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        valid_d   = valid_q;
        rd_wen_d  = rd_wen_q;
        rd_idx_d  = rd_idx_q;
        is_load_d = is_load_q;
        done_d    = done_q;

        // A load's result is never available from the EX channel
        for (int c = 0; c < NUM_DONE; c++) begin
            if (sb.done_valid[c] &&
                valid_q[sb.done_tag[c*TAG_WIDTH +: TAG_WIDTH]] &&
                (!is_load_q[sb.done_tag[c*TAG_WIDTH +: TAG_WIDTH]] ||
                 (c == int'(SB_DONE_LS)))) begin
                done_d[sb.done_tag[c*TAG_WIDTH +: TAG_WIDTH]] = 1'b1;
            end
        end

        valid_d = valid_d & ~w_kill;
        done_d  = done_d  & ~w_kill;

        if (w_retire_fire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + TAG_WIDTH'(1);
        end

        if (w_flush_fire) begin
            tail_d  = sb.flush_tag + TAG_WIDTH'(1);
            count_d = w_flush_cnt - (TAG_WIDTH+1)'(w_retire_fire);
        end else begin
            count_d = count_q + (TAG_WIDTH+1)'(w_issue_fire)
                              - (TAG_WIDTH+1)'(w_retire_fire);
        end

        if (w_issue_fire) begin
            valid_d[tail_q]   = 1'b1;
            rd_wen_d[tail_q]  = sb.issue_rd_wen && (sb.issue_rd_idx != '0);
            rd_idx_d[tail_q]  = sb.issue_rd_idx;
            is_load_d[tail_q] = sb.issue_is_load;
            done_d[tail_q]    = 1'b0;
            tail_d            = tail_q + TAG_WIDTH'(1);
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            valid_q   <= '0;
            rd_wen_q  <= '0;
            rd_idx_q  <= '0;
            is_load_q <= '0;
            done_q    <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            rd_wen_q  <= rd_wen_d;
            rd_idx_q  <= rd_idx_d;
            is_load_q <= is_load_d;
            done_q    <= done_d;
        end
    end

    core_id_sb_lookup #(
        .DEPTH       (DEPTH),
        .RFIDX_WIDTH (RFIDX_WIDTH),
        .FWD_EN      (c_FWD_EN)
    ) u_lookup_rs1 (
        .valid_i  (valid_q),
        .rd_wen_i (rd_wen_q),
        .rd_idx_i (rd_idx_q),
        .done_i   (done_q),
        .head_i   (head_q),
        .ren_i    (sb.rs1_ren),
        .idx_i    (sb.rs1_idx),
        .hit_o    (sb.rs1_hit),
        .tag_o    (sb.rs1_tag),
        .block_o  (w_block1)
    );

    core_id_sb_lookup #(
        .DEPTH       (DEPTH),
        .RFIDX_WIDTH (RFIDX_WIDTH),
        .FWD_EN      (c_FWD_EN)
    ) u_lookup_rs2 (
        .valid_i  (valid_q),
        .rd_wen_i (rd_wen_q),
        .rd_idx_i (rd_idx_q),
        .done_i   (done_q),
        .head_i   (head_q),
        .ren_i    (sb.rs2_ren),
        .idx_i    (sb.rs2_idx),
        .hit_o    (sb.rs2_hit),
        .tag_o    (sb.rs2_tag),
        .block_o  (w_block2)
    );

    assign sb.issue_ready = !w_full;
    assign sb.issue_tag   = tail_q;
    assign sb.empty       = w_empty;
    assign sb.id_stall    = w_full || w_block1 || w_block2;

endmodule

`default_nettype wire

// File: tb/tb_core_id_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_id_scoreboard
//  Description : Directed self-checking bench for core_id_scoreboard
//                (DEPTH=4). Expected stall values follow CORE_SB_FWD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_core_id_scoreboard;
    import core_id_scoreboard_pkg::*;

    localparam int DEPTH = 4;
    localparam int TW    = 2;
    localparam int RW    = 5;

`ifdef CORE_SB_FWD_EN
    localparam logic [31:0] c_FWD = 32'd1;
`else
    localparam logic [31:0] c_FWD = 32'd0;
`endif

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    core_id_scoreboard_if #(.TAG_WIDTH(TW), .RFIDX_WIDTH(RW), .NUM_DONE(2)) sb_if ();

    core_id_scoreboard #(.DEPTH(DEPTH), .RFIDX_WIDTH(RW), .NUM_DONE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.issue_valid   = 1'b0;
        sb_if.issue_rd_wen  = 1'b0;
        sb_if.issue_rd_idx  = '0;
        sb_if.issue_is_load = 1'b0;
        sb_if.done_valid    = '0;
        sb_if.done_tag      = '0;
        sb_if.retire_valid  = 1'b0;
        sb_if.flush_valid   = 1'b0;
        sb_if.flush_tag     = '0;
        sb_if.rs1_ren       = 1'b0;
        sb_if.rs1_idx       = '0;
        sb_if.rs2_ren       = 1'b0;
        sb_if.rs2_idx       = '0;
    endtask

    task automatic issue(input logic [RW-1:0] rd, input logic ld);
        sb_if.issue_valid   = 1'b1;
        sb_if.issue_rd_wen  = 1'b1;
        sb_if.issue_rd_idx  = rd;
        sb_if.issue_is_load = ld;
    endtask

    task automatic rs1(input logic [RW-1:0] idx);
        sb_if.rs1_ren = 1'b1;
        sb_if.rs1_idx = idx;
    endtask

    task automatic rs2(input logic [RW-1:0] idx);
        sb_if.rs2_ren = 1'b1;
        sb_if.rs2_idx = idx;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        idle();
        rst_n = 1'b0;
        rs1(5'd5);
        #12;
        chk("rst_ready",    32'(sb_if.issue_ready), 32'd1);
        chk("rst_empty",    32'(sb_if.empty),       32'd1);
        chk("rst_stall",    32'(sb_if.id_stall),    32'd0);
        chk("rst_hit",      32'(sb_if.rs1_hit),     32'd0);
        chk("rst_tag",      32'(sb_if.rs1_tag),     32'd0);
        chk("rst_issuetag", 32'(sb_if.issue_tag),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU RAW on x5
        idle(); issue(5'd5, 1'b0); #1;
        chk("alu_issuetag", 32'(sb_if.issue_tag), 32'd0);
        tick();
        idle(); rs1(5'd5);
        sb_if.done_valid = 2'b01; sb_if.done_tag = 4'b0000; #1;
        chk("alu_hit",       32'(sb_if.rs1_hit),  32'd1);
        chk("alu_tag",       32'(sb_if.rs1_tag),  32'd0);
        chk("alu_stall_pre", 32'(sb_if.id_stall), 32'd1);
        chk("alu_empty",     32'(sb_if.empty),    32'd0);
        tick();
        sb_if.done_valid = 2'b00; #1;
        chk("alu_stall_done", 32'(sb_if.id_stall), c_FWD ? 32'd0 : 32'd1);
        sb_if.retire_valid = 1'b1;
        tick();
        sb_if.retire_valid = 1'b0; #1;
        chk("alu_hit_ret",   32'(sb_if.rs1_hit),  32'd0);
        chk("alu_stall_ret", 32'(sb_if.id_stall), 32'd0);
        chk("alu_empty_ret", 32'(sb_if.empty),    32'd1);

        // Load-use on x6 (tag 1)
        idle(); issue(5'd6, 1'b1); #1;
        chk("ld_issuetag", 32'(sb_if.issue_tag), 32'd1);
        tick();
        idle(); rs2(5'd6); #1;
        chk("ld_hit",   32'(sb_if.rs2_hit),  32'd1);
        chk("ld_tag",   32'(sb_if.rs2_tag),  32'd1);
        chk("ld_stall", 32'(sb_if.id_stall), 32'd1);
        sb_if.done_valid = 2'b10; sb_if.done_tag = 4'b0100; #1;
        chk("ld_stall_same", 32'(sb_if.id_stall), 32'd1);
        tick();
        sb_if.done_valid = 2'b00; #1;
        chk("ld_stall_done", 32'(sb_if.id_stall), c_FWD ? 32'd0 : 32'd1);
        sb_if.retire_valid = 1'b1;
        tick();
        sb_if.retire_valid = 1'b0; #1;
        chk("ld_empty", 32'(sb_if.empty), 32'd1);

        // Youngest match: x7 at tags 2 and 3
        idle(); issue(5'd7, 1'b0); tick();
        issue(5'd7, 1'b0); tick();
        idle(); rs1(5'd7); #1;
        chk("yng_hit", 32'(sb_if.rs1_hit), 32'd1);
        chk("yng_tag", 32'(sb_if.rs1_tag), 32'd3);
        sb_if.retire_valid = 1'b1; tick();
        sb_if.retire_valid = 1'b0; #1;
        chk("yng_hit_r1", 32'(sb_if.rs1_hit), 32'd1);
        chk("yng_tag_r1", 32'(sb_if.rs1_tag), 32'd3);
        sb_if.retire_valid = 1'b1; tick();
        sb_if.retire_valid = 1'b0; #1;
        chk("yng_hit_r2", 32'(sb_if.rs1_hit), 32'd0);
        chk("yng_empty",  32'(sb_if.empty),   32'd1);

        // Full and wrap: x8..x11 at tags 0..3
        for (int i = 0; i < 4; i++) begin
            idle(); issue(RW'(8 + i), 1'b0); tick();
        end
        idle(); #1;
        chk("full_ready", 32'(sb_if.issue_ready), 32'd0);
        chk("full_stall", 32'(sb_if.id_stall),    32'd1);
        issue(5'd12, 1'b0); tick();
        idle(); rs1(5'd12); #1;
        chk("full_drop_hit", 32'(sb_if.rs1_hit), 32'd0);
        rs1(5'd8); #1;
        chk("full_x8_hit", 32'(sb_if.rs1_hit), 32'd1);
        chk("full_x8_tag", 32'(sb_if.rs1_tag), 32'd0);
        idle(); sb_if.retire_valid = 1'b1; tick();
        idle(); issue(5'd13, 1'b0); #1;
        chk("wrap_issuetag", 32'(sb_if.issue_tag), 32'd0);
        tick();
        idle(); rs1(5'd13); rs2(5'd8); #1;
        chk("wrap_ready",  32'(sb_if.issue_ready), 32'd0);
        chk("wrap_x13_hit", 32'(sb_if.rs1_hit),    32'd1);
        chk("wrap_x13_tag", 32'(sb_if.rs1_tag),    32'd0);
        chk("wrap_x8_hit",  32'(sb_if.rs2_hit),    32'd0);

        // Flush at tag 2 on a full, wrapped queue; issue the same cycle
        idle(); sb_if.flush_valid = 1'b1; sb_if.flush_tag = 2'd2;
        issue(5'd14, 1'b0); tick();
        idle(); rs1(5'd11); rs2(5'd13); #1;
        chk("fl_issuetag", 32'(sb_if.issue_tag),   32'd3);
        chk("fl_ready",    32'(sb_if.issue_ready), 32'd1);
        chk("fl_x11_hit",  32'(sb_if.rs1_hit),     32'd0);
        chk("fl_x13_hit",  32'(sb_if.rs2_hit),     32'd0);
        rs1(5'd10); rs2(5'd14); #1;
        chk("fl_x10_hit",  32'(sb_if.rs1_hit),     32'd1);
        chk("fl_x10_tag",  32'(sb_if.rs1_tag),     32'd2);
        chk("fl_x14_hit",  32'(sb_if.rs2_hit),     32'd0);
        idle(); sb_if.retire_valid = 1'b1; tick(); #1;
        chk("fl_empty_r1", 32'(sb_if.empty), 32'd0);
        tick();
        sb_if.retire_valid = 1'b0; #1;
        chk("fl_empty_r2", 32'(sb_if.empty), 32'd1);

        // x0 destination and asynchronous reset
        idle(); issue(5'd0, 1'b0); tick();
        idle(); rs1(5'd0); #1;
        chk("x0_hit",   32'(sb_if.rs1_hit), 32'd0);
        chk("x0_empty", 32'(sb_if.empty),   32'd0);
        idle(); issue(5'd20, 1'b0); tick();
        idle(); rs1(5'd20); #1;
        chk("x20_hit", 32'(sb_if.rs1_hit), 32'd1);
        rst_n = 1'b0; #1;
        chk("arst_empty",    32'(sb_if.empty),       32'd1);
        chk("arst_ready",    32'(sb_if.issue_ready), 32'd1);
        chk("arst_hit",      32'(sb_if.rs1_hit),     32'd0);
        chk("arst_issuetag", 32'(sb_if.issue_tag),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/core_id_scoreboard.md
Name: core_id_scoreboard

Overview:
- In-order in-flight instruction tracker for the 5-stage RV32 pipeline. It replaces ad-hoc per-stage forwarding compares in ID.
- ID pushes each issued instruction. EX/LS report result availability by tag. WB retires in order. An EX commit flush truncates younger entries.
- ID uses the combinational lookup outputs to stall on RAW hazards that forwarding cannot cover, and to select a forward source by tag.

Parameters:
- DEPTH, 4, max in-flight instructions ID→WB. Power of two, ≥2.
- RFIDX_WIDTH, 5, register index width. Equals `CORE_RFIDX_WIDTH.
- NUM_DONE, 2, result-available report channels. Channel 0 = EX, channel 1 = LS.
- Localparam TAG_WIDTH = clog2(DEPTH).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous reset, active-low
- issue_valid  in  1  ID issues an instruction this cycle
- issue_ready  out  1  slot free; equals !full
- issue_rd_wen  in  1  instruction writes rd
- issue_rd_idx  in  RFIDX_WIDTH  destination register
- issue_is_load  in  1  result not available at EX
- issue_tag  out  TAG_WIDTH  tag assigned to the current issue (= tail pointer)
- done_valid  in  NUM_DONE  per-channel result-available strobe
- done_tag  in  NUM_DONE*TAG_WIDTH  per-channel tag, packed
- retire_valid  in  1  WB retires the head entry
- flush_valid  in  1  commit flush from EX
- flush_tag  in  TAG_WIDTH  tag of the flushing instruction; that instruction survives
- rs1_ren, rs2_ren  in  1  source read enables
- rs1_idx, rs2_idx  in  RFIDX_WIDTH  source indices
- rs1_hit, rs2_hit  out  1  youngest in-flight writer of rsN exists
- rs1_tag, rs2_tag  out  TAG_WIDTH  tag of that writer
- id_stall  out  1  ID must hold its instruction
- empty  out  1  no entries in flight

Behaviour:
- Storage: circular queue of DEPTH entries, each {valid, rd_wen, rd_idx, is_load, done}. Head pointer, tail pointer, and occupancy count (TAG_WIDTH+1 bits). Pointers wrap modulo DEPTH.
- Reset (async): head=tail=count=0, all entries invalid. Outputs: issue_ready=1, empty=1, id_stall=0, hits=0, tags=0, issue_tag=0. Reset mid-operation discards all entries immediately.
- Issue: issue_valid && issue_ready && !flush_valid writes the entry at tail, advances tail, and increments count. rd_idx==0 forces rd_wen=0. done is initialised to 0.
- Issue while full: no effect. ID must see id_stall=1 in that case.
- Done: for each channel c, done_valid[c] sets done on the valid entry at done_tag[c]. Strobes to invalid entries are ignored. Multiple channels may target one entry.
- Retire: retire_valid pops the head: invalidate, head+1, count-1. retire_valid while empty is ignored.
- Flush:
  - tail ← flush_tag+1.
  - Entries strictly younger than flush_tag are invalidated the same edge.
  - count is recomputed as (flush_tag+1−head) mod DEPTH, minus 1 if a retire coincides. Full-queue wrap is disambiguated by the valid bit of flush_tag.
  - Flush + issue in the same cycle: flush wins, issue dropped.
  - Flush + retire in the same cycle: both apply; the result may be empty.
  - A done strobe to an entry flushed in the same cycle is dropped.
- Lookup (combinational, current state only, no same-cycle issue bypass):
  - rsN_hit = rsN_ren && rsN_idx≠0 && some valid entry has rd_wen && rd_idx==rsN_idx.
  - rsN_tag = the youngest such entry, found by priority search from tail−1 back to head.
- Stall: id_stall = (!issue_ready) || blockN for N=1,2.
  - blockN = rsN_hit && (youngest match !done) when forwarding is enabled.
  - blockN = rsN_hit when forwarding is disabled.
- Latency: state updates at the next clock edge. Lookup and stall are same-cycle combinational.

Optional Feature:
- Macro: CORE_SB_FWD_EN.
- Defined: a matching entry with done=1 does not stall; ID forwards from the stage identified by rsN_tag. This gives ALU back-to-back with no bubble; load-use stalls until the LS done strobe.
- Undefined: any pending writer stalls until retired. The done inputs are ignored, and their storage may be optimised away.

Decomposition:
- Shared constants go in core_defines.v: `CORE_RFIDX_WIDTH, `CORE_SB_DEPTH, `CORE_SB_DONE_EX=0, `CORE_SB_DONE_LS=1.
- One sub-module, core_id_sb_lookup: combinational youngest-match priority search over the entry array, given head/tail. Instantiated twice, once each for rs1 and rs2.

Test Plan:
- ALU RAW: issue x5 wr (tag0), done[0] tag0 next cycle, read rs1=x5 → rs1_hit=1, rs1_tag=0, id_stall=0 with FWD_EN; id_stall=1 without, until retire.
- Load-use: issue load x6 (tag1), read rs2=x6 → id_stall=1. done[1] tag1 → id_stall drops the next cycle.
- Youngest match: issue x7 at tag0 and x7 at tag1 (DEPTH=4), read x7 → rs1_tag=1. After retire tag0, still 1.
- Full/wrap: 4 issues without retire → issue_ready=0, id_stall=1. Retire then issue → issue_tag=0 (wrap), count=4.
- Flush: entries tags 0–3, flush_tag=1 → tail=2, count=2. Lookup of the rd at tag3 → hit=0. Same-cycle issue is ignored.
- x0 and reset: issue rd=x0, read x0 → hit=0. Assert rst_n mid-stream → empty=1, issue_ready=1 asynchronously.
